// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run/halt/single-step sequencer with load-use bubbles and taken-branch flushes.
// Define CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [31:0]      instruccion,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  output logic             pc_ena,
  output logic             ifid_ena,
  output logic             ifid_flush,
  output logic             ena,
  output logic             stop,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_STEP  = 3'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE     = 6'b000000;
  localparam logic [5:0] OP_STORE     = 6'b101000;
  localparam logic [5:0] OP_BRANCH    = 6'b000100;
  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

  state_t     r_state;
  logic [3:0] r_stall_cnt;
  logic       r_ret_step;

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_uses_rt;
  logic       w_load_use;
  logic       w_flush;
  logic       w_bubble;
  logic       w_advance;
  logic       w_unused;

  assign w_op      = instruccion[31:26];
  assign w_rs      = instruccion[25:21];
  assign w_rt      = instruccion[20:16];
  assign w_unused  = ^instruccion[15:0];
  assign w_uses_rt = (w_op == OP_RTYPE) | (w_op == OP_STORE) | (w_op == OP_BRANCH);
  // The load's destination register 0 is never a real dependency.
  assign w_load_use = idex_mem_read & (idex_rt != 5'd0) &
                      ((idex_rt == w_rs) | (w_uses_rt & (idex_rt == w_rt)));

  // Mealy action select: flush beats bubble beats advance while the pipe is live.
  always_comb begin
    w_flush   = 1'b0;
    w_bubble  = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_RUN, S_STEP: begin
        if (branch_taken) w_flush = 1'b1;
        else if (w_load_use) w_bubble = 1'b1;
        else w_advance = 1'b1;
      end
      S_STALL: w_bubble  = 1'b1;
      default: w_advance = 1'b0;
    endcase
  end

  assign pc_ena     = w_flush | w_advance;
  assign ifid_ena   = w_flush | w_advance;
  assign ifid_flush = w_flush;
  assign ena        = w_flush | w_bubble | w_advance;
  assign stop       = w_flush | w_bubble;
  assign busy       = (r_state != S_HALT);
  assign state      = r_state;

  // Sequencer state, remaining stall cycles and the return-to-step flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HALT;
      r_stall_cnt <= 4'd0;
      r_ret_step  <= 1'b0;
    end else begin
      case (r_state)
        S_HALT: begin
          r_ret_step <= 1'b0;
          if (run) r_state <= S_RUN;
          else if (step) r_state <= S_STEP;
          else r_state <= S_HALT;
        end
        S_RUN: begin
          if (w_bubble && MULTI_STALL) begin
            r_state     <= S_STALL;
            r_stall_cnt <= STALL_RELOAD;
            r_ret_step  <= 1'b0;
          end else if (w_bubble) begin
            r_state <= S_RUN;
          end else begin
            r_state <= run ? S_RUN : S_HALT;
          end
        end
        S_STALL: begin
          r_stall_cnt <= r_stall_cnt - 4'd1;
          if (r_stall_cnt <= 4'd1) r_state <= r_ret_step ? S_STEP : (run ? S_RUN : S_HALT);
          else r_state <= S_STALL;
        end
        S_STEP: begin
          // A step only completes once its instruction has actually entered decode.
          if (w_bubble && MULTI_STALL) begin
            r_state     <= S_STALL;
            r_stall_cnt <= STALL_RELOAD;
            r_ret_step  <= 1'b1;
          end else if (w_bubble) begin
            r_state <= S_STEP;
          end else begin
            r_state <= S_HALT;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

`ifdef CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  // Saturating event counters for bubble cycles and branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= {CNT_W{1'b0}};
      r_flush_count <= {CNT_W{1'b0}};
    end else begin
      if (w_bubble && (r_stall_count != CNT_MAX)) r_stall_count <= r_stall_count + CNT_ONE;
      if (w_flush && (r_flush_count != CNT_MAX)) r_flush_count <= r_flush_count + CNT_ONE;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  assign stall_count = {CNT_W{1'b0}};
  assign flush_count = {CNT_W{1'b0}};
`endif

endmodule
